// File: rtl/dmem_arbiter.sv
// Two-master data-memory arbiter: a loader (write-only) and the CPU share one
// memory port through an IDLE/ISSUE/WAIT/RESP handshake with timeout abort.
module dmem_arbiter #(
  parameter int ADDR_W   = 27,
  parameter int TIMEOUT  = 255,
  parameter int LD_BURST = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              ld_req,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [31:0]       ld_wdata,
  output logic              ld_ack,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_done,
  output logic              cpu_stall,
  output logic              mem_sig,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_finish,
  output logic              err
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);
  localparam logic [3:0] BURST_MAX = 4'(LD_BURST);

  logic [1:0] state_r;
  logic       grant_ld_r;
  logic [3:0] burst_cnt_r;
  logic [7:0] wait_cnt_r;

  logic       pick_ld_s;
  logic       timeout_s;
  logic [3:0] burst_next_s;

  // Grant selection and burst bookkeeping for the next IDLE->ISSUE decision
  always_comb begin
    pick_ld_s    = 1'b0;
    burst_next_s = 4'd0;
    timeout_s    = 1'b0;
    if (ld_req && (!cpu_req || (burst_cnt_r != BURST_MAX))) begin
      pick_ld_s = 1'b1;
    end else begin
      pick_ld_s = 1'b0;
    end
    // Loader streaks only count while the CPU is actually being held off
    if (pick_ld_s && cpu_req) begin
      burst_next_s = (burst_cnt_r >= BURST_MAX) ? BURST_MAX : (burst_cnt_r + 4'd1);
    end else begin
      burst_next_s = 4'd0;
    end
    if ((state_r == S_WAIT) && !mem_finish && (wait_cnt_r == WAIT_LAST)) begin
      timeout_s = 1'b1;
    end else begin
      timeout_s = 1'b0;
    end
  end

  assign cpu_stall = cpu_req & ~cpu_done;

  // Access sequencer: latches the granted request and drives all registered outputs
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r     <= S_IDLE;
      grant_ld_r  <= 1'b0;
      burst_cnt_r <= 4'd0;
      wait_cnt_r  <= 8'd0;
      mem_sig     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= 32'd0;
      cpu_rdata   <= 32'd0;
      ld_ack      <= 1'b0;
      cpu_done    <= 1'b0;
      err         <= 1'b0;
    end else begin
      mem_sig  <= 1'b0;
      ld_ack   <= 1'b0;
      cpu_done <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (ld_req || cpu_req) begin
            state_r     <= S_ISSUE;
            mem_sig     <= 1'b1;
            grant_ld_r  <= pick_ld_s;
            burst_cnt_r <= burst_next_s;
            if (pick_ld_s) begin
              mem_we    <= 1'b1;
              mem_addr  <= ld_addr;
              mem_wdata <= ld_wdata;
            end else begin
              mem_we    <= cpu_we;
              mem_addr  <= cpu_addr;
              mem_wdata <= cpu_wdata;
            end
          end
        end
        S_ISSUE: begin
          state_r    <= S_WAIT;
          wait_cnt_r <= 8'd0;
        end
        S_WAIT: begin
          if (mem_finish || timeout_s) begin
            state_r  <= S_RESP;
            ld_ack   <= grant_ld_r;
            cpu_done <= ~grant_ld_r;
            if (mem_finish && !grant_ld_r && !mem_we) begin
              cpu_rdata <= mem_rdata;
            end
            // An abort leaves cpu_rdata untouched and flags the error for good
            if (!mem_finish) begin
              err <= 1'b1;
            end
          end else begin
            wait_cnt_r <= wait_cnt_r + 8'd1;
          end
        end
        S_RESP: begin
          state_r <= S_IDLE;
        end
        default: begin
          state_r <= S_IDLE;
        end
      endcase
    end
  end

endmodule
